// File: rtl/seq_dff_capture_ctrl_if.sv
// Bus between the serial source / parallel consumer and the DFF capture controller.
interface seq_dff_capture_ctrl_if #(
  parameter int NBITS = 8,
  parameter int CW    = $clog2(NBITS + 1)
);
  logic             start;
  logic             a;
  logic             out_rdy;
  logic [NBITS-1:0] q;
  logic [CW-1:0]    count;
  logic             busy;
  logic             out_val;

  // Source/consumer side drives requests and data, observes the word.
  modport master (output start, a, out_rdy, input q, count, busy, out_val);
  // Controller side.
  modport slave  (input start, a, out_rdy, output q, count, busy, out_val);
endinterface

// File: rtl/seq_dff_capture_ctrl.sv
// Sequencer for a bank of NBITS DFFs loaded serially (MSB first) after a
// start pulse; the full word is offered with a valid/ready handshake.
module seq_dff_capture_ctrl #(
  parameter int NBITS = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  seq_dff_capture_ctrl_if.slave bus
);
  localparam int CW = $clog2(NBITS + 1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_WAIT} state_t;

  state_t           state_q, state_d;
  logic [NBITS-1:0] q_q, q_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  // State, DFF bank and bit counter; reset discards any partial word.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      q_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; a only reaches the bank in SHIFT so it is don't-care elsewhere.
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_SHIFT;
          q_d     = '0;
          cnt_d   = '0;
        end
      end
      S_SHIFT: begin
        q_d   = {q_q[NBITS-2:0], bus.a};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(NBITS - 1)) state_d = S_WAIT;
      end
      S_WAIT: begin
        // Accept with start in the same cycle restarts without an idle bubble.
        if (bus.out_rdy) begin
          if (bus.start) begin
            state_d = S_SHIFT;
            q_d     = '0;
            cnt_d   = '0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs come straight from registers or a state decode only.
  assign bus.q       = q_q;
  assign bus.count   = cnt_q;
  assign bus.busy    = (state_q != S_IDLE);
  assign bus.out_val = (state_q == S_WAIT);

endmodule

// File: tb/tb_seq_dff_capture_ctrl.sv
// Bench: two instances (NBITS=8 and NBITS=4) driven from one stimulus stream,
// each compared every cycle to a word-level model; directed checks on top.
module tb_seq_dff_capture_ctrl;
  logic clk = 1'b0;
  logic reset, start, a, out_rdy;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  seq_dff_capture_ctrl_if #(.NBITS(8)) bus8 ();
  seq_dff_capture_ctrl_if #(.NBITS(4)) bus4 ();

  assign bus8.start = start;   assign bus4.start = start;
  assign bus8.a = a;           assign bus4.a = a;
  assign bus8.out_rdy = out_rdy; assign bus4.out_rdy = out_rdy;

  seq_dff_capture_ctrl #(.NBITS(8)) u_dut8 (.clk(clk), .reset(reset), .bus(bus8));
  seq_dff_capture_ctrl #(.NBITS(4)) u_dut4 (.clk(clk), .reset(reset), .bus(bus4));

  // Model: word value, bits taken, whether a word is being shifted or is held.
  int NB[2] = '{8, 4};
  int mq[2], mc[2];
  bit msh[2], mfull[2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic mdl_edge();
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        mq[i] = 0; mc[i] = 0; msh[i] = 0; mfull[i] = 0;
      end else if (msh[i]) begin
        mq[i] = ((mq[i] * 2) + int'(a)) % (1 << NB[i]);
        mc[i] = mc[i] + 1;
        if (mc[i] == NB[i]) begin msh[i] = 0; mfull[i] = 1; end
      end else if (mfull[i]) begin
        if (out_rdy) begin
          mfull[i] = 0;
          if (start) begin msh[i] = 1; mq[i] = 0; mc[i] = 0; end
        end
      end else if (start) begin
        msh[i] = 1; mq[i] = 0; mc[i] = 0;
      end
    end
  endtask

  task automatic cmp_all();
    chk("q8",    32'(bus8.q),       32'(mq[0]));
    chk("cnt8",  32'(bus8.count),   32'(mc[0]));
    chk("busy8", 32'(bus8.busy),    32'(msh[0] | mfull[0]));
    chk("val8",  32'(bus8.out_val), 32'(mfull[0]));
    chk("q4",    32'(bus4.q),       32'(mq[1]));
    chk("cnt4",  32'(bus4.count),   32'(mc[1]));
    chk("busy4", 32'(bus4.busy),    32'(msh[1] | mfull[1]));
    chk("val4",  32'(bus4.out_val), 32'(mfull[1]));
  endtask

  // Apply inputs for one cycle, advance model at the edge, check just after.
  task automatic step(input logic s, input logic av, input logic r, input logic rs);
    start = s; a = av; out_rdy = r; reset = rs;
    @(posedge clk);
    mdl_edge();
    #1;
    cmp_all();
  endtask

  task automatic shift_word(input logic [7:0] w, input int n, input logic s);
    for (int i = n - 1; i >= 0; i--) step(s, w[i], 1'b0, 1'b0);
  endtask

  initial begin
    start = 0; a = 0; out_rdy = 0; reset = 1;
    // Reset then idle with a toggling.
    step(0, 0, 0, 1); step(0, 1, 0, 1);
    chk("rst_q8", 32'(bus8.q), 32'h0);
    chk("rst_busy8", 32'(bus8.busy), 32'h0);
    for (int i = 0; i < 5; i++) step(0, 1'(i), 0, 0);
    chk("idle_val8", 32'(bus8.out_val), 32'h0);

    // Single capture 0xB2 with consumer stalled.
    step(1, 0, 0, 0);
    chk("sh_busy", 32'(bus8.busy), 32'h1);
    chk("sh_cnt0", 32'(bus8.count), 32'h0);
    shift_word(8'hB2, 8, 1'b0);
    chk("b2_q", 32'(bus8.q), 32'hB2);
    chk("b2_cnt", 32'(bus8.count), 32'd8);
    chk("b2_val", 32'(bus8.out_val), 32'h1);
    for (int i = 0; i < 4; i++) step(0, 1'(i), 0, 0);
    chk("b2_hold", 32'(bus8.q), 32'hB2);

    // Back-to-back: accept and restart in the same cycle, shift 0x5A.
    step(1, 0, 1, 0);
    chk("b2b_busy", 32'(bus8.busy), 32'h1);
    chk("b2b_val", 32'(bus8.out_val), 32'h0);
    chk("b2b_cnt", 32'(bus8.count), 32'h0);
    shift_word(8'h5A, 8, 1'b0);
    chk("5a_q", 32'(bus8.q), 32'h5A);
    chk("5a_val", 32'(bus8.out_val), 32'h1);
    step(0, 0, 1, 0);
    chk("5a_idle", 32'(bus8.busy), 32'h0);
    chk("5a_keep", 32'(bus8.q), 32'h5A);

    // Start held high through SHIFT and WAIT of 0xFF.
    step(0, 0, 0, 1);
    step(1, 0, 0, 0);
    shift_word(8'hFF, 8, 1'b1);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0);
    chk("ff_q", 32'(bus8.q), 32'hFF);
    chk("ff_wait", 32'(bus8.out_val), 32'h1);
    step(0, 0, 1, 0);

    // Reset mid-shift, then fresh 0x81.
    step(0, 0, 0, 1);
    step(1, 0, 0, 0);
    shift_word(8'h07, 3, 1'b0);
    step(0, 1, 0, 1);
    chk("rs_q", 32'(bus8.q), 32'h0);
    chk("rs_busy", 32'(bus8.busy), 32'h0);
    step(1, 0, 0, 0);
    shift_word(8'h81, 8, 1'b0);
    chk("81_q", 32'(bus8.q), 32'h81);
    // Reset while holding a word.
    step(1, 1, 0, 1);
    chk("rw_val", 32'(bus8.out_val), 32'h0);
    chk("rw_cnt", 32'(bus8.count), 32'h0);

    // Narrow instance: 1,1,0,1 gives 0xD after 4 bits.
    step(1, 0, 0, 0);
    shift_word(8'h0D, 4, 1'b0);
    chk("n4_q", 32'(bus4.q), 32'hD);
    chk("n4_cnt", 32'(bus4.count), 32'd4);
    chk("n4_val", 32'(bus4.out_val), 32'h1);

    // Random traffic with occasional reset.
    for (int i = 0; i < 1500; i++)
      step(1'($urandom_range(0, 3) == 0), 1'($urandom), 1'($urandom_range(0, 2) == 0),
           1'($urandom_range(0, 60) == 0));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
